nmr_echo_sum_accumulator: RTL

//  Sits directly downstream of the NMR pulse-program controller and consumes its ADC sample stream
//  (data + valid). Sums sample k of every echo in a scan into an on-chip buffer (echo co-addition),

---
 rtl/nmr_pkg.sv | 19 +
 rtl/nmr_sum_ram.sv | 31 +++
 rtl/nmr_echo_sum_accumulator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/nmr_pkg.sv
// Shared definitions for the NMR echo co-addition block.
// Contents: default widths used as parameter defaults and the run-control
// state encoding.
package nmr_pkg;

    localparam int unsigned ADC_DATA_WIDTH_DEF         = 16;
    localparam int unsigned SAMPLES_PER_ECHO_WIDTH_DEF = 32;
    localparam int unsigned ECHO_PER_SCAN_WIDTH_DEF    = 32;
    localparam int unsigned SUM_WIDTH_DEF              = 32;
    localparam int unsigned BUF_ADDR_WIDTH_DEF         = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DRAIN   = 2'd2,
        DONE_ST = 2'd3
    } nmr_state_t;

endpackage

// File: rtl/nmr_sum_ram.sv
// Simple dual-port sum buffer: one write port, one synchronous read port.
// A read addressing the word being written on the same edge returns the old
// contents (read-first); the accumulator resolves that case with a bypass.
// The read register only updates when rd_en is high, so read data is held
// until the consumer asks for the next word.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr    read request, data appears on rd_data after one edge
//   rd_data          registered read data
module nmr_sum_ram #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/nmr_echo_sum_accumulator.sv
// Echo co-addition: sums sample k of every echo of a scan into an on-chip
// buffer, then drains the per-sample sums over a valid/ready stream.
// Ports:
//   ADC_CLK, RESET_N          clock, asynchronous active-low reset
//   START                     1-cycle pulse: latch config, (re)start a run
//   SAMPLES_PER_ECHO          samples per echo
//   ECHO_PER_SCAN             echoes per scan
//   ADC_IN_DATA/ADC_IN_VALID  sample stream, no backpressure
//   SUM_OUT_DATA/VALID/READY/LAST   result stream, one beat per index
//   BUSY                      accumulating or draining
//   DONE                      1-cycle pulse at end of run
//   CFG_ERR                   sticky: SAMPLES_PER_ECHO exceeds buffer depth
module nmr_echo_sum_accumulator
    import nmr_pkg::*;
#(
    parameter int unsigned ADC_DATA_WIDTH         = ADC_DATA_WIDTH_DEF,
    parameter int unsigned SAMPLES_PER_ECHO_WIDTH = SAMPLES_PER_ECHO_WIDTH_DEF,
    parameter int unsigned ECHO_PER_SCAN_WIDTH    = ECHO_PER_SCAN_WIDTH_DEF,
    parameter int unsigned SUM_WIDTH              = SUM_WIDTH_DEF,
    parameter int unsigned BUF_ADDR_WIDTH         = BUF_ADDR_WIDTH_DEF
) (
    input  logic                              ADC_CLK,
    input  logic                              RESET_N,
    input  logic                              START,
    input  logic [SAMPLES_PER_ECHO_WIDTH-1:0] SAMPLES_PER_ECHO,
    input  logic [ECHO_PER_SCAN_WIDTH-1:0]    ECHO_PER_SCAN,
    input  logic [ADC_DATA_WIDTH-1:0]         ADC_IN_DATA,
    input  logic                              ADC_IN_VALID,
    output logic [SUM_WIDTH-1:0]              SUM_OUT_DATA,
    output logic                              SUM_OUT_VALID,
    input  logic                              SUM_OUT_READY,
    output logic                              SUM_OUT_LAST,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              CFG_ERR
);

    localparam int unsigned SPE_W = SAMPLES_PER_ECHO_WIDTH;
    localparam int unsigned EPS_W = ECHO_PER_SCAN_WIDTH;
    localparam int unsigned AW    = BUF_ADDR_WIDTH;
    localparam int unsigned DEPTH = 1 << BUF_ADDR_WIDTH;
    localparam int unsigned CNT_W = BUF_ADDR_WIDTH + 1;

    nmr_state_t           state;
    logic [SPE_W-1:0]     spe_r, k_cnt;
    logic [EPS_W-1:0]     eps_r, e_cnt;
    logic                 accum_closed;
    logic                 s0_valid, s0_end, s0_first, s0_byp;
    logic [AW-1:0]        s0_addr;
    logic [SUM_WIDTH-1:0] s0_data, byp_val;
    logic [CNT_W-1:0]     drain_len, drain_addr;
    logic                 rd_valid, rd_last;
    logic [SUM_WIDTH-1:0] out_data;
    logic                 out_valid, out_last, done_r, cfg_err_r;

    logic                 accept, k_in_range, k_wrap, is_last, rd_en, consume;
    logic [AW-1:0]        k_addr, rd_addr;
    logic [SUM_WIDTH-1:0] operand, sum, ram_q;

    always_comb begin
        k_wrap     = (k_cnt == spe_r - SPE_W'(1));
        is_last    = k_wrap && (e_cnt == eps_r - EPS_W'(1));
        k_in_range = (k_cnt < SPE_W'(DEPTH));
        k_addr     = k_cnt[AW-1:0];
        accept     = (state == ACCUM) && ADC_IN_VALID && !accum_closed && !START;
        // Stage 1 writes on the same edge stage 0 reads; take the fresh sum
        // from the bypass register instead of the stale RAM word.
        operand    = s0_byp ? byp_val : ram_q;
        sum        = s0_first ? s0_data : operand + s0_data;
        // RAM read register acts as a one-entry prefetch buffer in front of
        // the output register, giving one beat per cycle with READY high.
        consume    = rd_valid && (!out_valid || SUM_OUT_READY);
        rd_en      = accept ||
                     ((state == DRAIN) && (drain_addr < drain_len) && (!rd_valid || consume));
        rd_addr    = (state == DRAIN) ? drain_addr[AW-1:0] : k_addr;
    end

    nmr_sum_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (SUM_WIDTH)
    ) u_ram (
        .clk     (ADC_CLK),
        .wr_en   (s0_valid),
        .wr_addr (s0_addr),
        .wr_data (sum),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge ADC_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            spe_r        <= '0;
            eps_r        <= '0;
            k_cnt        <= '0;
            e_cnt        <= '0;
            accum_closed <= 1'b0;
            s0_valid     <= 1'b0;
            s0_end       <= 1'b0;
            s0_first     <= 1'b0;
            s0_byp       <= 1'b0;
            s0_addr      <= '0;
            s0_data      <= '0;
            byp_val      <= '0;
            drain_len    <= '0;
            drain_addr   <= '0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            done_r       <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            s0_valid <= 1'b0;
            s0_end   <= 1'b0;

            // Stage 0: accept sample, RAM read of mem[k] is issued alongside.
            // Out-of-range indices still advance the counters but never write.
            if (accept) begin
                s0_valid <= k_in_range;
                s0_end   <= is_last;
                s0_addr  <= k_addr;
                s0_data  <= SUM_WIDTH'(ADC_IN_DATA);
                s0_first <= (e_cnt == '0);
                s0_byp   <= s0_valid && (s0_addr == k_addr);
                byp_val  <= sum;
                if (!k_in_range) cfg_err_r <= 1'b1;
                if (is_last) accum_closed <= 1'b1;
                if (k_wrap) begin
                    k_cnt <= '0;
                    e_cnt <= e_cnt + EPS_W'(1);
                end else begin
                    k_cnt <= k_cnt + SPE_W'(1);
                end
            end

            if (state == DRAIN) begin
                if (rd_en) begin
                    drain_addr <= drain_addr + CNT_W'(1);
                    rd_valid   <= 1'b1;
                    rd_last    <= (drain_addr == drain_len - CNT_W'(1));
                end else if (consume) begin
                    rd_valid <= 1'b0;
                end
            end

            if (consume) begin
                out_valid <= 1'b1;
                out_data  <= ram_q;
                out_last  <= rd_last;
            end else if (out_valid && SUM_OUT_READY) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                ACCUM:   if (s0_end) state <= DRAIN;
                DRAIN:   if (out_valid && SUM_OUT_READY && out_last) state <= DONE_ST;
                DONE_ST: begin
                    state  <= IDLE;
                    done_r <= 1'b1;
                end
                default: ;
            endcase

            // START overrides everything above: abort and relaunch.
            if (START) begin
                state        <= ((SAMPLES_PER_ECHO == '0) || (ECHO_PER_SCAN == '0)) ? DONE_ST : ACCUM;
                spe_r        <= SAMPLES_PER_ECHO;
                eps_r        <= ECHO_PER_SCAN;
                drain_len    <= (SAMPLES_PER_ECHO > SPE_W'(DEPTH)) ? CNT_W'(DEPTH)
                                                                   : SAMPLES_PER_ECHO[CNT_W-1:0];
                cfg_err_r    <= (SAMPLES_PER_ECHO > SPE_W'(DEPTH));
                k_cnt        <= '0;
                e_cnt        <= '0;
                accum_closed <= 1'b0;
                s0_valid     <= 1'b0;
                s0_end       <= 1'b0;
                s0_byp       <= 1'b0;
                drain_addr   <= '0;
                rd_valid     <= 1'b0;
                out_valid    <= 1'b0;
                out_last     <= 1'b0;
                done_r       <= 1'b0;
            end
        end
    end

    assign SUM_OUT_DATA  = out_data;
    assign SUM_OUT_VALID = out_valid;
    assign SUM_OUT_LAST  = out_last;
    assign BUSY          = (state == ACCUM) || (state == DRAIN);
    assign DONE          = done_r;
    assign CFG_ERR       = cfg_err_r;

endmodule
